// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: program counter, ROM address, IF/ID register
// Redirects (branch over jump) bubble IF/ID and override a decode stall.
module instr_fetch #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP      = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Stall,
  input  logic              BranchTaken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              JumpEn,
  input  logic [ADDR_W-1:0] JumpTarget,
  output logic [ADDR_W-1:0] RomAddr,
  input  logic [DATA_W-1:0] RomInstr,
  output logic [DATA_W-1:0] IfId_Instr,
  output logic [ADDR_W-1:0] IfId_PC,
  output logic [ADDR_W-1:0] IfId_PCPlus1,
  output logic              IfId_Valid
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;

  assign RomAddr  = pc;
  assign pc_plus1 = pc + 1'b1;

  // A taken branch is older than the jump in decode, so it wins.
  always_comb begin
    redirect        = BranchTaken | JumpEn;
    redirect_target = JumpTarget;
    if (BranchTaken)
      redirect_target = BranchTarget;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc           <= RESET_PC;
      IfId_Instr   <= NOP;
      IfId_PC      <= '0;
      IfId_PCPlus1 <= '0;
      IfId_Valid   <= 1'b0;
    end else if (redirect) begin
      // Bubble uses the NOP constant so an undriven ROM word never enters decode.
      pc           <= redirect_target;
      IfId_Instr   <= NOP;
      IfId_PC      <= '0;
      IfId_PCPlus1 <= '0;
      IfId_Valid   <= 1'b0;
    end else if (!Stall) begin
      pc           <= pc_plus1;
      IfId_Instr   <= RomInstr;
      IfId_PC      <= pc;
      IfId_PCPlus1 <= pc_plus1;
      IfId_Valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
// Reference model tracks the architectural PC and IF/ID contents per clock edge.
module tb_instr_fetch;

  localparam int AW = 10;
  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          Stall, BranchTaken, JumpEn;
  logic [AW-1:0] BranchTarget, JumpTarget;
  logic [AW-1:0] RomAddr;
  logic [DW-1:0] RomInstr;
  logic [DW-1:0] IfId_Instr;
  logic [AW-1:0] IfId_PC, IfId_PCPlus1;
  logic          IfId_Valid;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  instr_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JumpEn(JumpEn), .JumpTarget(JumpTarget),
    .RomAddr(RomAddr), .RomInstr(RomInstr),
    .IfId_Instr(IfId_Instr), .IfId_PC(IfId_PC),
    .IfId_PCPlus1(IfId_PCPlus1), .IfId_Valid(IfId_Valid)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return {6'b0, a} + 16'h0100;
  endfunction

  always_comb RomInstr = rom(RomAddr);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: architectural state after each edge.
  int m_pc = 0, m_instr = 0, m_ifpc = 0, m_ifpc1 = 0, m_valid = 0;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_pc = 0; m_instr = 0; m_ifpc = 0; m_ifpc1 = 0; m_valid = 0;
    end else if (BranchTaken || JumpEn) begin
      m_pc    = BranchTaken ? int'(BranchTarget) : int'(JumpTarget);
      m_instr = 0; m_ifpc = 0; m_ifpc1 = 0; m_valid = 0;
    end else if (!Stall) begin
      m_instr = int'(rom(AW'(m_pc)));
      m_ifpc  = m_pc;
      m_ifpc1 = (m_pc + 1) % (1 << AW);
      m_valid = 1;
      m_pc    = (m_pc + 1) % (1 << AW);
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      check("cyc_RomAddr",      int'(RomAddr),      m_pc);
      check("cyc_IfId_Instr",   int'(IfId_Instr),   m_instr);
      check("cyc_IfId_PC",      int'(IfId_PC),      m_ifpc);
      check("cyc_IfId_PCPlus1", int'(IfId_PCPlus1), m_ifpc1);
      check("cyc_IfId_Valid",   int'(IfId_Valid),   m_valid);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge Clk);
      #2;
    end
  endtask

  task automatic idle();
    Stall = 0; BranchTaken = 0; JumpEn = 0;
    BranchTarget = '0; JumpTarget = '0;
  endtask

  initial begin
    Reset_n = 1'b0;
    idle();
    tick(2);
    chk_en = 1'b1;
    check("rst_RomAddr", int'(RomAddr), 0);
    check("rst_Valid",   int'(IfId_Valid), 0);
    check("rst_Instr",   int'(IfId_Instr), 0);
    Reset_n = 1'b1;

    // 1: free run
    tick(4);
    check("t1_RomAddr", int'(RomAddr), 4);
    check("t1_Instr",   int'(IfId_Instr), 16'h0103);
    check("t1_Valid",   int'(IfId_Valid), 1);
    tick(2);

    // 2: stall at PC=6
    check("t2_pre_RomAddr", int'(RomAddr), 6);
    Stall = 1;
    tick(3);
    check("t2_RomAddr", int'(RomAddr), 6);
    check("t2_IfId_PC", int'(IfId_PC), 5);
    check("t2_Instr",   int'(IfId_Instr), 16'h0105);
    Stall = 0;
    tick(1);
    check("t2_release", int'(RomAddr), 7);
    tick(1);

    // 3: jump from PC=8
    check("t3_pre_RomAddr", int'(RomAddr), 8);
    JumpEn = 1; JumpTarget = 10'd40;
    tick(1);
    idle();
    check("t3_RomAddr", int'(RomAddr), 40);
    check("t3_Valid",   int'(IfId_Valid), 0);
    check("t3_Instr",   int'(IfId_Instr), 0);
    tick(1);
    check("t3_IfId_PC", int'(IfId_PC), 40);
    check("t3_Valid1",  int'(IfId_Valid), 1);
    check("t3_Instr1",  int'(IfId_Instr), 16'h0128);

    // 4: branch beats jump and stall
    BranchTaken = 1; BranchTarget = 10'd100;
    JumpEn = 1; JumpTarget = 10'd200; Stall = 1;
    tick(1);
    idle();
    check("t4_RomAddr", int'(RomAddr), 100);
    check("t4_Valid",   int'(IfId_Valid), 0);
    tick(1);
    check("t4_IfId_PC", int'(IfId_PC), 100);

    // 5: wrap at top of address space
    JumpEn = 1; JumpTarget = 10'd1022;
    tick(1);
    idle();
    check("t5_RomAddr0", int'(RomAddr), 1022);
    tick(1);
    check("t5_RomAddr1", int'(RomAddr), 1023);
    tick(1);
    check("t5_RomAddr2", int'(RomAddr), 0);
    check("t5_IfId_PC",  int'(IfId_PC), 1023);
    check("t5_PCPlus1",  int'(IfId_PCPlus1), 0);
    tick(1);
    check("t5_RomAddr3", int'(RomAddr), 1);

    // 6: asynchronous reset mid-run
    JumpEn = 1; JumpTarget = 10'd300;
    tick(1);
    idle();
    tick(1);
    check("t6_pre_IfId_PC", int'(IfId_PC), 300);
    Stall = 1;
    Reset_n = 1'b0;
    #1;
    check("t6_RomAddr", int'(RomAddr), 0);
    check("t6_Valid",   int'(IfId_Valid), 0);
    check("t6_IfId_PC", int'(IfId_PC), 0);
    tick(1);
    Stall = 0;
    Reset_n = 1'b1;
    tick(2);
    check("t6_restart_RomAddr", int'(RomAddr), 2);
    check("t6_restart_IfId_PC", int'(IfId_PC), 1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
